// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, default abort timeout and stage-control bundle for pipe_ctrl.
package pipe_ctrl_pkg;

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StLuStall = 2'd1;
  localparam logic [1:0] StMwait   = 2'd2;

  localparam int unsigned TimeoutDefault = 200;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } ctrl_t;

  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c          = '0;
    c.pc_we    = 1'b1;
    c.ifid_we  = 1'b1;
    c.idex_we  = 1'b1;
    c.exmem_we = 1'b1;
    c.memwb_we = 1'b1;
    return c;
  endfunction

  // Whole front end held; WB keeps draining with a bubble so no result retires twice.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c              = '0;
    c.memwb_we     = 1'b1;
    c.memwb_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory wait with timeout,
// plus saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             b_jump,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned      WaitW    = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  ctrl_t            ctrl;
  logic             mem_err_c;
  logic             mem_wait;

  assign mem_wait = dmem_req & ~dmem_ready;

  always_comb begin
    ctrl      = ctrl_default();
    mem_err_c = 1'b0;
    state_d   = StRun;
    wait_d    = wait_q;

    case (state_q)
      StRun, StLuStall: begin
        if (mem_wait) begin
          ctrl    = ctrl_freeze();
          state_d = StMwait;
          wait_d  = '0;
        end else if (b_jump) begin
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
        end else if (stall_req && (state_q == StRun)) begin
          ctrl.pc_we      = 1'b0;
          ctrl.ifid_we    = 1'b0;
          ctrl.idex_flush = 1'b1;
          state_d         = StLuStall;
        end
      end

      StMwait: begin
        if (dmem_ready) begin
          // Release: anything held during the wait is honoured now.
          if (b_jump) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (stall_req) begin
            ctrl.pc_we      = 1'b0;
            ctrl.ifid_we    = 1'b0;
            ctrl.idex_flush = 1'b1;
            state_d         = StLuStall;
          end
        end else if (wait_q == WaitLast) begin
          // Abort release; the access is still outstanding, so stall_req stays masked here.
          mem_err_c = 1'b1;
          if (b_jump) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
          end
        end else begin
          ctrl    = ctrl_freeze();
          state_d = StMwait;
          if (wait_q != '1) begin
            wait_d = wait_q + WaitW'(1);
          end
        end
      end

      default: ;
    endcase

    if (rst) begin
      ctrl      = ctrl_default();
      mem_err_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign pc_we        = ctrl.pc_we;
  assign ifid_we      = ctrl.ifid_we;
  assign idex_we      = ctrl.idex_we;
  assign exmem_we     = ctrl.exmem_we;
  assign memwb_we     = ctrl.memwb_we;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign mem_err      = mem_err_c;
  assign state        = state_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .inc   (~ctrl.pc_we),
    .clear (rst),
    .q     (stall_cycles)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .inc   (ctrl.ifid_flush),
    .clear (rst),
    .q     (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short timeout and narrow counters to reach saturation.
module tb_pipe_ctrl;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_req, b_jump, dmem_req, dmem_ready;
  logic            pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic            ifid_flush, idex_flush, memwb_bubble;
  logic [1:0]      state;
  logic            mem_err;
  logic [CntW-1:0] stall_cycles, flush_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_err   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .b_jump       (b_jump),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .idex_we      (idex_we),
    .exmem_we     (exmem_we),
    .memwb_we     (memwb_we),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_bubble (memwb_bubble),
    .state        (state),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge, drive inputs, let combinational outputs settle.
  task automatic drive(input logic r, input logic s, input logic b, input logic q,
                       input logic rdy);
    @(negedge clk);
    rst        = r;
    stall_req  = s;
    b_jump     = b;
    dmem_req   = q;
    dmem_ready = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_req = 1'b1; b_jump = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;

    // Reset with every hazard input active: defaults only, nothing counted
    drive(1, 1, 1, 1, 0);
    chk("rst_state", state, 0);
    chk("rst_pc_we", pc_we, 1);
    chk("rst_ifid_flush", ifid_flush, 0);
    chk("rst_bubble", memwb_bubble, 0);
    chk("rst_mem_err", mem_err, 0);
    drive(1, 1, 1, 1, 0);
    chk("rst_stall_cnt", stall_cycles, 0);
    chk("rst_flush_cnt", flush_count, 0);

    // Load-use: stall_req held 2 cycles
    drive(0, 1, 0, 0, 0);
    chk("lu_pc_we", pc_we, 0);
    chk("lu_ifid_we", ifid_we, 0);
    chk("lu_idex_flush", idex_flush, 1);
    chk("lu_idex_we", idex_we, 1);
    drive(0, 1, 0, 0, 0);
    chk("lu_state", state, 1);
    chk("lu_masked_pc_we", pc_we, 1);
    chk("lu_masked_flush", idex_flush, 0);
    drive(0, 0, 0, 0, 0);
    chk("lu_back_run", state, 0);
    chk("lu_stall_cnt", stall_cycles, 1);
    chk("lu_flush_cnt", flush_count, 0);

    // Branch beats load-use
    drive(0, 1, 1, 0, 0);
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_flush", idex_flush, 1);
    chk("br_pc_we", pc_we, 1);
    drive(0, 0, 0, 0, 0);
    chk("br_state", state, 0);
    chk("br_flush_cnt", flush_count, 1);
    chk("br_stall_cnt", stall_cycles, 1);

    // Memory wait: ready low 3 cycles then high
    drive(0, 0, 0, 1, 0);
    chk("mw1_bubble", memwb_bubble, 1);
    chk("mw1_pc_we", pc_we, 0);
    chk("mw1_memwb_we", memwb_we, 1);
    chk("mw1_exmem_we", exmem_we, 0);
    drive(0, 0, 0, 1, 0);
    chk("mw2_state", state, 2);
    chk("mw2_bubble", memwb_bubble, 1);
    drive(0, 0, 0, 1, 0);
    chk("mw3_bubble", memwb_bubble, 1);
    drive(0, 0, 0, 1, 1);
    chk("mw4_state", state, 2);
    chk("mw4_pc_we", pc_we, 1);
    chk("mw4_bubble", memwb_bubble, 0);
    drive(0, 0, 0, 0, 0);
    chk("mw_state_run", state, 0);
    chk("mw_stall_cnt", stall_cycles, 4);

    // Branch held through a 2-cycle wait: flush only on release
    drive(0, 0, 1, 1, 0);
    chk("hb1_flush", ifid_flush, 0);
    drive(0, 0, 1, 1, 0);
    chk("hb2_state", state, 2);
    chk("hb2_flush", ifid_flush, 0);
    drive(0, 0, 1, 1, 1);
    chk("hb3_ifid_flush", ifid_flush, 1);
    chk("hb3_idex_flush", idex_flush, 1);
    chk("hb3_pc_we", pc_we, 1);
    drive(0, 0, 0, 0, 0);
    chk("hb_state", state, 0);
    chk("hb_flush_cnt", flush_count, 2);
    chk("hb_stall_cnt", stall_cycles, 6);

    // Timeout, with stall_req active during the freeze (must not matter)
    drive(0, 1, 0, 1, 0);
    chk("to_run_pc_we", pc_we, 0);
    chk("to_run_idex_flush", idex_flush, 0);
    chk("to_run_bubble", memwb_bubble, 1);
    drive(0, 1, 0, 1, 0);
    chk("to_w1_idex_flush", idex_flush, 0);
    chk("to_w1_mem_err", mem_err, 0);
    drive(0, 0, 0, 1, 0);
    chk("to_w2_mem_err", mem_err, 0);
    drive(0, 0, 0, 1, 0);
    chk("to_w3_mem_err", mem_err, 0);
    drive(0, 0, 0, 1, 0);
    chk("to_w4_mem_err", mem_err, 1);
    chk("to_w4_pc_we", pc_we, 1);
    chk("to_w4_bubble", memwb_bubble, 0);
    drive(0, 0, 0, 0, 0);
    chk("to_state_run", state, 0);
    chk("to_mem_err_gone", mem_err, 0);
    chk("to_stall_cnt", stall_cycles, 10);

    // Reset at wait_cnt=2
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("rm_state", state, 2);
    chk("rm_wait_cnt", dut.wait_q, 2);
    drive(1, 0, 0, 1, 0);
    chk("rm_rst_pc_we", pc_we, 1);
    chk("rm_rst_bubble", memwb_bubble, 0);
    chk("rm_rst_mem_err", mem_err, 0);
    drive(0, 0, 0, 0, 0);
    chk("rm_state_run", state, 0);
    chk("rm_stall_cnt", stall_cycles, 0);
    chk("rm_flush_cnt", flush_count, 0);
    n_err = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      if (mem_err) n_err++;
    end
    chk("rm_no_mem_err", n_err, 0);

    // Repeated timeouts: 16 frozen cycles saturate a 4-bit counter at 15
    n_err = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 1, 0);
      if (mem_err) n_err++;
    end
    chk("sat_mem_err_pulses", n_err, 4);
    drive(0, 0, 0, 0, 0);
    chk("sat_stall_cnt", stall_cycles, 15);
    chk("sat_state", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
